pipelined_control_unit: RTL

Next-generation control unit for the 4-stage-after-fetch pipeline (ID/EX/MEM/WB). Decodes the ID-stage opcode with the established ISA table and carries control bits through the ID/EX, EX/MEM and MEM/WB stage registers. It also generates pipeline stalls internally instead of taking them from outside. New behaviour:
- load-use hazard detection
- multi-cycle MUL occupancy counter
- sticky HALT
- illegal-opcode flagging for widened opcodes

---
 rtl/cu_pkg.sv | 43 ++++
 rtl/cu_checker.sv | 14 +
 rtl/cu_decoder.sv | 63 ++++++
 rtl/pipelined_control_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the pipelined control unit: ISA opcodes, immediate
// select encodings and the control bundle carried through the stage registers.
package cu_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_JALR = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_JAL  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] IMM_J    = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_U    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  typedef struct packed {
    logic reg_write;
    logic result_src;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jump;
    logic is_mul;
    logic halt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(9'd0);

endpackage

// File: rtl/cu_checker.sv
// Protocol checks for the control unit's sideband inputs.
module cu_checker (
  input logic clk,
  input logic rst,
  input logic flush,
  input logic ext_stall,
  input logic mul_busy
);

  // A flush while a MUL still occupies EX is tolerated but signals an upstream sequencing bug.
  a_no_flush_during_mul: assert property (@(posedge clk) disable iff (rst)
    !(flush && !ext_stall && mul_busy));

endmodule

// File: rtl/cu_decoder.sv
// Pure combinational ID-stage decode: opcode to control bundle, immediate
// select and an illegal flag for opcodes beyond the 16-entry ISA table.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic [1:0]          imm_src,
  output logic                illegal
);

  logic upper_nz;

  if (OPCODE_W > 4) begin : g_wide
    assign upper_nz = |opcode[OPCODE_W-1:4];
  end else begin : g_narrow
    assign upper_nz = 1'b0;
  end

  // Opcode table lookup; widened opcodes fall through to a NOP.
  always_comb begin
    ctrl    = CTRL_NOP;
    imm_src = IMM_NONE;
    illegal = 1'b0;
    if (upper_nz) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: ctrl.reg_write = 1'b1;
        OP_LUI: begin
          imm_src = IMM_U; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_LW: begin
          imm_src = IMM_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
          ctrl.result_src = 1'b1; ctrl.mem_read = 1'b1;
        end
        OP_SW: begin
          imm_src = IMM_I; ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        end
        OP_ADDI: begin
          imm_src = IMM_I; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_JALR: begin
          imm_src = IMM_J; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          imm_src = IMM_I; ctrl.branch = 1'b1;
        end
        OP_JAL: begin
          imm_src = IMM_J; ctrl.jump = 1'b1;
        end
        OP_MUL: begin
          ctrl.reg_write = 1'b1; ctrl.is_mul = 1'b1;
        end
        OP_HALT: ctrl.halt = 1'b1;
        default: ctrl = CTRL_NOP;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX/MEM/WB control pipeline with internal load-use and MUL-occupancy
// stall generation, flush handling, illegal-opcode pulse and sticky halt.
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int REG_ADDR_W  = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   opcode_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [1:0]            id_ImmSrc,
  output logic                  stall_if_id,
  output logic                  ex_ALUSrc,
  output logic                  ex_Branch,
  output logic                  ex_Jump,
  output logic                  ex_is_mul,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  wb_RegWrite,
  output logic                  wb_ResultSrc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  mul_busy,
  output logic                  illegal_op,
  output logic                  halted
);

  localparam logic [CNT_W-1:0]      MUL_INIT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [REG_ADDR_W-1:0] RD_ZERO  = {REG_ADDR_W{1'b0}};

  ctrl_t id_ctrl, ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic illegal_q, illegal_d, halted_q, halted_d;
  logic id_illegal, load_use, busy;

  cu_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (opcode_id),
    .ctrl    (id_ctrl),
    .imm_src (id_ImmSrc),
    .illegal (id_illegal)
  );

  cu_checker u_chk (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .ext_stall (ext_stall),
    .mul_busy  (busy)
  );

  assign busy     = (mul_cnt_q != {CNT_W{1'b0}});
  assign load_use = ex_ctrl_q.mem_read && (ex_rd_q != RD_ZERO) &&
                    ((ex_rd_q == rs1_id) || (ex_rd_q == rs2_id));

  // Hazard priority: ext_stall > flush > MUL occupancy > halt/load-use > advance.
  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_rd_d    = mem_rd_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_rd_d     = wb_rd_q;
    mul_cnt_d   = mul_cnt_q;
    illegal_d   = 1'b0;
    halted_d    = halted_q | wb_ctrl_q.halt;
    stall_if_id = 1'b1;
    if (ext_stall) begin
      stall_if_id = 1'b1;
    end else begin
      wb_ctrl_d = mem_ctrl_q;
      wb_rd_d   = mem_rd_q;
      if (flush) begin
        stall_if_id = halted_q;
        ex_ctrl_d   = CTRL_NOP;
        ex_rd_d     = RD_ZERO;
        mul_cnt_d   = {CNT_W{1'b0}};
        if (busy) begin
          mem_ctrl_d = CTRL_NOP;
          mem_rd_d   = RD_ZERO;
        end else begin
          mem_ctrl_d = ex_ctrl_q;
          mem_rd_d   = ex_rd_q;
        end
      end else if (busy) begin
        mem_ctrl_d = CTRL_NOP;
        mem_rd_d   = RD_ZERO;
        mul_cnt_d  = mul_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (halted_q || load_use) begin
        mem_ctrl_d = ex_ctrl_q;
        mem_rd_d   = ex_rd_q;
        ex_ctrl_d  = CTRL_NOP;
        ex_rd_d    = RD_ZERO;
      end else begin
        stall_if_id = 1'b0;
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        ex_ctrl_d   = id_ctrl;
        ex_rd_d     = rd_id;
        illegal_d   = id_illegal;
        mul_cnt_d   = id_ctrl.is_mul ? MUL_INIT : {CNT_W{1'b0}};
      end
    end
  end

  // Stage registers, MUL counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q  <= CTRL_NOP;
      mem_ctrl_q <= CTRL_NOP;
      wb_ctrl_q  <= CTRL_NOP;
      ex_rd_q    <= RD_ZERO;
      mem_rd_q   <= RD_ZERO;
      wb_rd_q    <= RD_ZERO;
      mul_cnt_q  <= {CNT_W{1'b0}};
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      mem_rd_q   <= mem_rd_d;
      wb_rd_q    <= wb_rd_d;
      mul_cnt_q  <= mul_cnt_d;
      illegal_q  <= illegal_d;
      halted_q   <= halted_d;
    end
  end

  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_ctrl_q.mem_read, wb_ctrl_q.mem_write, wb_ctrl_q.alu_src,
                            wb_ctrl_q.branch, wb_ctrl_q.jump, wb_ctrl_q.is_mul};

  assign ex_ALUSrc    = ex_ctrl_q.alu_src;
  assign ex_Branch    = ex_ctrl_q.branch;
  assign ex_Jump      = ex_ctrl_q.jump;
  assign ex_is_mul    = ex_ctrl_q.is_mul;
  assign mem_MemRead  = mem_ctrl_q.mem_read;
  assign mem_MemWrite = mem_ctrl_q.mem_write;
  assign wb_RegWrite  = wb_ctrl_q.reg_write;
  assign wb_ResultSrc = wb_ctrl_q.result_src;
  assign ex_rd        = ex_rd_q;
  assign mem_rd       = mem_rd_q;
  assign wb_rd        = wb_rd_q;
  assign mul_busy     = busy;
  assign illegal_op   = illegal_q;
  assign halted       = halted_q;

endmodule
